systolic_tile_seq: RTL and testbench

Tile sequencer for the weight-stationary systolic array. Per tile, it runs three phases with ready/valid handshakes:
- load H weight rows into the array;
- stream a programmable number of activation vectors;
- drain the skewed pipeline until every partial-sum vector has left.

It drives the array's weight/partial-sum select and global advance enable. It tracks in-flight vectors so the output side sees an exact `psum_valid` strobe. It sits between the input/weight buffers and the array.

---
 rtl/systolic_tile_seq.sv | 135 +++++++++++++
 tb/tb_systolic_tile_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_tile_seq.sv
// Tile sequencer for a weight-stationary systolic array: load weights, stream activations,
// drain the skewed pipeline. Optional stall counter built when SYS_SEQ_PERF_EN is defined.
module systolic_tile_seq #(
  parameter int unsigned H  = 32,
  parameter int unsigned W  = 32,
  parameter int unsigned NW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] num_vec,
  output logic          busy,
  output logic          done,
  input  logic          wbuf_valid,
  output logic          wbuf_ready,
  input  logic          act_valid,
  output logic          act_ready,
  input  logic          out_ready,
  output logic          w_ps,
  output logic          arr_en,
  output logic          psum_valid,
  output logic [31:0]   stall_cycles
);

  localparam int unsigned LAT = H + W - 1;
  localparam int unsigned RW  = (H > 1) ? $clog2(H) : 1;
  localparam logic [RW-1:0] RowLast = RW'(H - 1);

  typedef enum logic [1:0] {StIdle, StLoadW, StStream, StDrain} state_e;

  state_e          state_q;
  logic [RW-1:0]   row_cnt_q;
  logic [NW-1:0]   vec_cnt_q;
  logic [NW-1:0]   num_vec_q;
  logic [LAT-1:0]  pend_q;
  logic [LAT-1:0]  pend_d;
  logic [LAT:0]    pend_ext;
  logic            done_q;

  always_comb begin
    wbuf_ready = 1'b0;
    act_ready  = 1'b0;
    arr_en     = 1'b0;
    w_ps       = 1'b0;
    unique case (state_q)
      StLoadW: begin
        w_ps       = 1'b1;
        wbuf_ready = 1'b1;
        arr_en     = wbuf_valid;
      end
      StStream: begin
        act_ready = out_ready;
        arr_en    = act_valid & out_ready;
      end
      StDrain:  arr_en = out_ready;
      default:  ;
    endcase
  end

  // A 1 enters the pending line for each streamed vector; its exit marks a real psum.
  always_comb begin
    pend_ext   = {pend_q, (state_q == StStream)};
    pend_d     = arr_en ? pend_ext[LAT-1:0] : pend_q;
    psum_valid = arr_en & pend_q[LAT-1];
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      row_cnt_q <= '0;
      vec_cnt_q <= '0;
      num_vec_q <= '0;
      pend_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      pend_q <= pend_d;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            num_vec_q <= num_vec;
            row_cnt_q <= '0;
            vec_cnt_q <= '0;
            state_q   <= StLoadW;
          end
        end
        StLoadW: begin
          if (wbuf_valid) begin
            row_cnt_q <= row_cnt_q + RW'(1);
            if (row_cnt_q == RowLast) begin
              state_q <= (num_vec_q == '0) ? StDrain : StStream;
            end
          end
        end
        StStream: begin
          if (arr_en) begin
            vec_cnt_q <= vec_cnt_q + NW'(1);
            if (vec_cnt_q == num_vec_q - NW'(1)) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (pend_d == '0) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SYS_SEQ_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (state_q == StIdle && start) begin
      stall_q <= '0;
    end else if (busy && !arr_en && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_tile_seq.sv
// Directed bench for systolic_tile_seq with H=W=4 (LAT=7) and a 4-bit vector count.
module tb_systolic_tile_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  num_vec;
  logic        busy;
  logic        done;
  logic        wbuf_valid;
  logic        wbuf_ready;
  logic        act_valid;
  logic        act_ready;
  logic        out_ready;
  logic        w_ps;
  logic        arr_en;
  logic        psum_valid;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  logic [31:0] wps_m, acc_m, wacc_m, psv_m, done_m, busy_m, arr_m, warr_m;

  systolic_tile_seq #(
    .H  (4),
    .W  (4),
    .NW (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_vec      (num_vec),
    .busy         (busy),
    .done         (done),
    .wbuf_valid   (wbuf_valid),
    .wbuf_ready   (wbuf_ready),
    .act_valid    (act_valid),
    .act_ready    (act_ready),
    .out_ready    (out_ready),
    .w_ps         (w_ps),
    .arr_en       (arr_en),
    .psum_valid   (psum_valid),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One tile; cycle 0 carries the start pulse. Per-cycle outputs are collected into masks.
  task automatic run(input logic [3:0] nv, input int n, input bit wtog, input int st_at,
                     input int st_len, input int pulse_at, input int rst_at);
    wps_m = '0; acc_m = '0; wacc_m = '0; psv_m = '0;
    done_m = '0; busy_m = '0; arr_m = '0; warr_m = '0;
    for (int c = 0; c < n; c++) begin
      start      = (c == 0) || (c == pulse_at);
      num_vec    = (c == 0) ? nv : 4'd9;
      wbuf_valid = wtog ? (c % 2 == 1) : 1'b1;
      act_valid  = 1'b1;
      out_ready  = !(c >= st_at && c < st_at + st_len);
      rst        = (c != rst_at);
      #1;
      if (c < 32) begin
        wps_m[c]  = w_ps;
        acc_m[c]  = act_valid & act_ready;
        wacc_m[c] = wbuf_valid & wbuf_ready;
        psv_m[c]  = psum_valid;
        done_m[c] = done;
        busy_m[c] = busy;
        arr_m[c]  = arr_en;
        warr_m[c] = arr_en & w_ps;
      end
      tick();
    end
    start = 1'b0;
    rst   = 1'b1;
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b1;
    num_vec    = 4'd5;
    wbuf_valid = 1'b1;
    act_valid  = 1'b1;
    out_ready  = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_busy",       {31'd0, busy},       32'd0);
    chk("rst_done",       {31'd0, done},       32'd0);
    chk("rst_wps",        {31'd0, w_ps},       32'd0);
    chk("rst_arr_en",     {31'd0, arr_en},     32'd0);
    chk("rst_psum_valid", {31'd0, psum_valid}, 32'd0);
    chk("rst_wbuf_ready", {31'd0, wbuf_ready}, 32'd0);
    chk("rst_act_ready",  {31'd0, act_ready},  32'd0);
    chk("rst_stall",      stall_cycles,        32'd0);
    rst   = 1'b1;
    start = 1'b0;
    tick();

    // Basic tile, num_vec=3
    run(4'd3, 20, 1'b0, -1, 0, -1, -1);
    chk("t1_wps",  wps_m,  32'h0000_001E);
    chk("t1_acc",  acc_m,  32'h0000_00E0);
    chk("t1_psv",  psv_m,  32'h0000_7000);
    chk("t1_done", done_m, 32'h0000_8000);
    chk("t1_busy", busy_m, 32'h0000_7FFE);
    chk("t1_stall", stall_cycles, 32'd0);

    // num_vec=0
    run(4'd0, 12, 1'b0, -1, 0, -1, -1);
    chk("t2_wps",  wps_m,  32'h0000_001E);
    chk("t2_busy", busy_m, 32'h0000_003E);
    chk("t2_done", done_m, 32'h0000_0040);
    chk("t2_psv",  psv_m,  32'h0000_0000);
    chk("t2_acc",  acc_m,  32'h0000_0000);

    // Toggling wbuf_valid
    run(4'd3, 22, 1'b1, -1, 0, -1, -1);
    chk("t3_wacc", wacc_m, 32'h0000_00AA);
    chk("t3_wps",  wps_m,  32'h0000_00FE);
    chk("t3_warr", warr_m, 32'h0000_00AA);
    chk("t3_acc",  acc_m,  32'h0000_0700);
    chk("t3_psv",  psv_m,  32'h0003_8000);
    chk("t3_done", done_m, 32'h0004_0000);
`ifdef SYS_SEQ_PERF_EN
    chk("t3_stall", stall_cycles, 32'd3);
`else
    chk("t3_stall", stall_cycles, 32'd0);
`endif

    // out_ready low for cycles 9-13 inside DRAIN
    run(4'd3, 24, 1'b0, 9, 5, -1, -1);
    chk("t4_arr_stall", arr_m & 32'h0000_3E00, 32'h0);
    chk("t4_psv",  psv_m,  32'h000E_0000);
    chk("t4_done", done_m, 32'h0010_0000);
`ifdef SYS_SEQ_PERF_EN
    chk("t4_stall", stall_cycles, 32'd5);
`else
    chk("t4_stall", stall_cycles, 32'd0);
`endif

    // start with num_vec=9 during STREAM is ignored
    run(4'd3, 24, 1'b0, -1, 0, 6, -1);
    chk("t5_acc",  acc_m,  32'h0000_00E0);
    chk("t5_psv",  psv_m,  32'h0000_7000);
    chk("t5_done", done_m, 32'h0000_8000);
    chk("t5_busy", busy_m, 32'h0000_7FFE);

    // Reset sampled at end of cycle 6 (STREAM)
    run(4'd3, 20, 1'b0, -1, 0, -1, 6);
    chk("t6_busy", busy_m, 32'h0000_007E);
    chk("t6_acc",  acc_m,  32'h0000_0060);
    chk("t6_psv",  psv_m,  32'h0000_0000);
    chk("t6_done", done_m, 32'h0000_0000);
    run(4'd3, 20, 1'b0, -1, 0, -1, -1);
    chk("t6_rerun_psv",  psv_m,  32'h0000_7000);
    chk("t6_rerun_done", done_m, 32'h0000_8000);

    // Full-scale count 2^NW-1
    run(4'd15, 31, 1'b0, -1, 0, -1, -1);
    chk("t7_acc",  acc_m,  32'h000F_FFE0);
    chk("t7_psv",  psv_m,  32'h07FF_F000);
    chk("t7_done", done_m, 32'h0800_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
